// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for the multi-cycle MIPS-subset core. It steps each instruction
//   through FETCH / DECODE / EXECUTE / MEM / WB, steering the shared ALU, the
//   unified memory port, IR, PC and register file. Memory accesses may stall on
//   mem_ready. Undecodable opcodes and memory timeouts trap into a sticky error
//   state that only reset leaves.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   op              opcode IR[31:26], stable from DECODE to end of instruction
//   zero            ALU zero flag, used by BEQ/BNE
//   mem_ready       memory completes the access presented this cycle
//   mem_req/mem_we/iord            memory request, write strobe, address select
//   ir_write/pc_write/pc_src       IR load, PC load and PC source select
//   alu_src_a/alu_src_b/alu_op     ALU operand and operation selects
//   reg_write/reg_dst/mem_to_reg   register file write controls
//   instr_done      one-cycle pulse in the last cycle of a retired instruction
//   illegal/bus_err sticky trap flags (illegal opcode / memory timeout)

module multicycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // A zero-width counter is not legal, so MAX_WAIT=0 (no timeout) keeps one bit.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ERR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic          in_mem;
    logic          timeout;
    logic          set_illegal;

    // The wait counter only means something while a memory access is pending.
    // A ready in the last allowed cycle still completes: ready wins over timeout.
    assign in_mem  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout = (MAX_WAIT > 0) && in_mem && !mem_ready && (wait_cnt == LAST_WAIT);

    // Next-state selection; DECODE flags undecodable opcodes for the trap.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        case (state)
            S_RST:    next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_ERR;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_RTYPE:       next_state = S_EXEC;
                    OP_ADDI:        next_state = S_ADDIEX;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    default: begin
                        next_state  = S_ERR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)    next_state = S_MEMWB;
                else if (timeout) next_state = S_ERR;
            end
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_ERR;
            end
            S_EXEC:   next_state = S_RWB;
            S_RWB:    next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_ERR:    next_state = S_ERR;
            default:  next_state = S_ERR;
        endcase
    end

    // State, wait counter and sticky trap flags. The counter only grows while a
    // memory state stalls in place; any other transition leaves it cleared, so
    // every fresh FETCH/MEMRD/MEMWR starts counting from zero. Only one trap can
    // fire because ERR is never left without reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (in_mem && !mem_ready && !timeout) wait_cnt <= wait_cnt + CW'(1);
            else                                  wait_cnt <= '0;
            if (set_illegal) illegal <= 1'b1;
            if (timeout)     bus_err <= 1'b1;
        end
    end

    // Control outputs decode from the state; only FETCH, MEMWR and BRANCH also
    // look at mem_ready or zero. RST and ERR leave everything low.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. The driver plays each instruction out
//   on a cycle schedule derived from the instruction's latency rules and pushes
//   the expected retirement (or trap) into a queue; an independent monitor pops
//   and compares whenever the DUT pulses instr_done or raises a trap flag.

module tb_multicycle_ctrl;

    localparam int MAX_WAIT = 15;
    localparam int K_RETIRE = 0;
    localparam int K_ILL    = 1;
    localparam int K_BUS    = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct {
        int          kind;
        int          lat;
        logic [14:0] bundle;
        int          req_cycles;
        int          we_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg;
    logic       instr_done, illegal, bus_err;
    logic [14:0] bundle;

    assign bundle = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                     alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg};

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .illegal(illegal), .bus_err(bus_err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single place where comparisons are counted and failures reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    endfunction

    function automatic bit is_mem(input logic [5:0] o);
        return (o == OP_LW) || (o == OP_SW);
    endfunction

    // FETCH-to-FETCH cycles with no wait states.
    function automatic int base_latency(input logic [5:0] o);
        if (o == OP_LW) return 5;
        if (o == OP_SW || o == OP_RTYPE || o == OP_ADDI) return 4;
        return 3;
    endfunction

    // Control outputs expected in the cycle an instruction retires.
    function automatic logic [14:0] retire_bundle(input logic [5:0] o, input logic z);
        logic       mreq = 0, mwe = 0, io = 0, irw = 0, pw = 0, asa = 0;
        logic       rw = 0, rdst = 0, m2r = 0;
        logic [1:0] psrc = 2'b00, asb = 2'b00, aop = 2'b00;
        case (o)
            OP_LW:    begin rw = 1; m2r = 1; end
            OP_SW:    begin mreq = 1; mwe = 1; io = 1; end
            OP_RTYPE: begin rw = 1; rdst = 1; end
            OP_ADDI:  rw = 1;
            OP_BEQ:   begin asa = 1; aop = 2'b01; psrc = 2'b01; pw = z; end
            OP_BNE:   begin asa = 1; aop = 2'b01; psrc = 2'b01; pw = !z; end
            OP_J:     begin psrc = 2'b10; pw = 1; end
            default: ;
        endcase
        return {mreq, mwe, io, irw, pw, psrc, asa, asb, aop, rw, rdst, m2r};
    endfunction

    // One schedule cycle: inputs change just after the active edge.
    task automatic drive_cycle(input logic ready);
        @(posedge clk);
        #1;
        mem_ready = ready;
    endtask

    // Assert reset between edges, check outputs drop at once, release, and
    // check the RST cycle presents no memory request.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs", {instr_done, illegal, bus_err, bundle}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_state_mem_req", mem_req, 1'b0);
    endtask

    // Play one instruction with fw fetch wait cycles and mw data wait cycles.
    // A wait count of MAX_WAIT or more means that access never completes.
    task automatic applyStimulus(input logic [5:0] o, input logic z, input int fw,
                                 input int mw, output int kind);
        exp_t e;
        int   n;
        logic r;
        bit   sw;
        sw = (o == OP_SW);
        e.bundle     = retire_bundle(o, z);
        e.req_cycles = fw + 1 + (is_mem(o) ? mw + 1 : 0);
        e.we_cycles  = sw ? mw + 1 : 0;
        if (fw >= MAX_WAIT) begin
            e.kind = K_BUS;
            e.lat  = MAX_WAIT + 1;
        end else if (!is_legal(o)) begin
            e.kind = K_ILL;
            e.lat  = fw + 3;
        end else if (is_mem(o) && mw >= MAX_WAIT) begin
            e.kind = K_BUS;
            e.lat  = fw + MAX_WAIT + 4;
        end else begin
            e.kind = K_RETIRE;
            e.lat  = base_latency(o) + fw + (is_mem(o) ? mw : 0);
        end
        exp_q.push_back(e);
        kind = e.kind;

        n = (fw >= MAX_WAIT) ? MAX_WAIT : fw + 1;
        for (int i = 0; i < n; i++) begin
            r = (i == fw);
            drive_cycle(r);
            if (i == 0) begin
                op   = o;
                zero = z;
            end
            #1;
            checkOutput("fetch_outputs", {instr_done, bundle},
                        {1'b0, 1'b1, 1'b0, 1'b0, r, r, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000});
        end
        if (fw >= MAX_WAIT) return;

        drive_cycle(1'($urandom));
        if (!is_legal(o)) return;

        if (is_mem(o)) begin
            drive_cycle(1'($urandom));
            n = (mw >= MAX_WAIT) ? MAX_WAIT : mw + 1;
            for (int i = 0; i < n; i++) begin
                r = (i == mw);
                drive_cycle(r);
                #1;
                checkOutput("mem_access", {instr_done, mem_req, mem_we, iord},
                            {sw && r, 1'b1, sw, 1'b1});
            end
            if (mw >= MAX_WAIT) return;
            if (o == OP_LW) drive_cycle(1'($urandom));
        end else if (o == OP_RTYPE || o == OP_ADDI) begin
            repeat (2) drive_cycle(1'($urandom));
        end else begin
            drive_cycle(1'($urandom));
        end
    endtask

    // After a trap, everything but the trap flag stays low until reset.
    task automatic holdErr(input int cycles, input logic [1:0] flags);
        for (int i = 0; i < cycles; i++) begin
            drive_cycle(1'($urandom));
            #1;
            checkOutput("err_outputs", {instr_done, bundle}, 32'h0);
            checkOutput("err_flags", {illegal, bus_err}, flags);
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
        int kind;
        applyStimulus(o, z, fw, mw, kind);
        if (kind != K_RETIRE) begin
            holdErr(20, (kind == K_ILL) ? 2'b10 : 2'b01);
            do_reset();
        end
    endtask

    // Monitor: counts cycles and memory activity since the last retirement and
    // checks them, plus the retire-cycle outputs, against the scoreboard.
    int  mon_cnt, mon_req, mon_we;
    bit  mon_trap;
    exp_t mon_e;
    initial begin
        mon_cnt  = -1;
        mon_req  = 0;
        mon_we   = 0;
        mon_trap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_cnt  = -1;
                mon_req  = 0;
                mon_we   = 0;
                mon_trap = 0;
            end else begin
                mon_cnt++;
                if (mem_req) mon_req++;
                if (mem_we)  mon_we++;
                if (instr_done) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_retire: got instr_done=1, expected none pending (t=%0t)", $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("event_kind", K_RETIRE, mon_e.kind);
                        checkOutput("latency", mon_cnt, mon_e.lat);
                        checkOutput("retire_outputs", bundle, mon_e.bundle);
                        checkOutput("mem_req_cycles", mon_req, mon_e.req_cycles);
                        checkOutput("mem_we_cycles", mon_we, mon_e.we_cycles);
                    end
                    mon_cnt = 0;
                    mon_req = 0;
                    mon_we  = 0;
                end
                if ((illegal || bus_err) && !mon_trap) begin
                    mon_trap = 1;
                    checkOutput("trap_exclusive", illegal && bus_err, 1'b0);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_trap: got illegal=%0b bus_err=%0b, expected none (t=%0t)",
                                 illegal, bus_err, $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("event_kind", illegal ? K_ILL : K_BUS, mon_e.kind);
                        checkOutput("trap_latency", mon_cnt, mon_e.lat);
                    end
                end
            end
        end
    end

    // Directed cases first, then randomized instruction mix.
    initial begin
        logic [5:0] o;
        int         sel, fw, mw, r;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        op          = 6'b0;
        zero        = 1'b0;
        mem_ready   = 1'b0;

        do_reset();
        run_instr(OP_LW, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, 3);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_BNE, 1'b1, 0, 0);
        run_instr(OP_BNE, 1'b0, 0, 0);
        run_instr(OP_J, 1'b0, 1, 0);
        run_instr(OP_RTYPE, 1'b0, 0, 0);
        run_instr(OP_ADDI, 1'b1, 2, 0);
        run_instr(OP_LW, 1'b0, MAX_WAIT - 1, MAX_WAIT - 1);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(OP_RTYPE, 1'b0, MAX_WAIT, 0);
        run_instr(OP_LW, 1'b0, 1, MAX_WAIT);
        run_instr(OP_SW, 1'b1, 0, MAX_WAIT);

        // Reset in the middle of a stalled load.
        drive_cycle(1'b1);
        op = OP_LW;
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        #1;
        checkOutput("memrd_before_reset", {mem_req, iord, mem_we}, 3'b110);
        do_reset();
        run_instr(OP_ADDI, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 8);
            case (sel)
                0: o = OP_RTYPE;
                1: o = OP_ADDI;
                2: o = OP_LW;
                3: o = OP_SW;
                4: o = OP_BEQ;
                5: o = OP_BNE;
                6: o = OP_J;
                7: o = OP_LW;
                default: begin
                    o = 6'($urandom);
                    if (is_legal(o)) o = 6'b111111;
                end
            endcase
            r  = $urandom_range(0, 19);
            fw = (r < 16) ? r % 4 : (r < 19) ? MAX_WAIT - 1 : MAX_WAIT;
            r  = $urandom_range(0, 19);
            mw = (r < 16) ? r % 4 : (r < 19) ? MAX_WAIT - 1 : MAX_WAIT;
            run_instr(o, 1'($urandom), fw, mw);
        end

        repeat (3) drive_cycle(1'b0);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Backstop so the run always ends even if the schedule somehow stalls.
    initial begin
        #1000000;
        miscompares++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
